// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: sequencing controller for a time-multiplexed single-MAC FIR with a circular delay line
module fir_mac_sequencer #(
   parameter int TAPS  = 9,
   parameter int AW    = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic             dl_we,
   output logic             dl_wzero,
   output logic [AW-1:0]    dl_waddr,
   output logic [AW-1:0]    dl_raddr,
   output logic [AW-1:0]    coef_addr,
   output logic             mac_clr,
   output logic             mac_en,
   output logic             out_valid,
   output logic             busy,
   output logic [CNT_W-1:0] sample_count,
   output logic [CNT_W-1:0] out_count
);
   typedef enum logic [2:0] {S_CLEAR_INIT, S_CLEAR, S_IDLE, S_WRITE, S_MAC, S_DONE} state_t;
   localparam logic [AW-1:0] L_LAST = AW'(TAPS - 1);
   localparam logic [AW:0]   L_TAPS = (AW+1)'(TAPS);
   state_t        r_state;
   logic [AW-1:0] r_wptr, r_cnt, r_flush_rem;
   logic          r_zero_pass, r_flush_pend, r_flush_act;
   logic [AW-1:0] w_t_nxt, w_rd_nxt, w_wptr_nxt;
   logic          w_hs, w_pend_nxt;

   // Next tap index, its circular read address, the advanced write pointer and flush bookkeeping
   always_comb begin
      w_t_nxt    = (r_state == S_MAC) ? r_cnt + 1'b1 : '0;
      w_rd_nxt   = (r_wptr >= w_t_nxt) ? r_wptr - w_t_nxt : AW'({1'b0, r_wptr} + L_TAPS - {1'b0, w_t_nxt});
      w_wptr_nxt = (r_wptr == L_LAST) ? '0 : r_wptr + 1'b1;
      w_hs       = in_valid & in_ready;
      w_pend_nxt = r_flush_pend | (flush & ~r_flush_act);
   end

   // Single registered FSM: each output is produced for the state being entered so all ports are flops
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_CLEAR_INIT;
         r_wptr       <= '0;
         r_cnt        <= '0;
         r_flush_rem  <= '0;
         r_zero_pass  <= 1'b0;
         r_flush_pend <= 1'b0;
         r_flush_act  <= 1'b0;
         in_ready     <= 1'b0;
         dl_we        <= 1'b0;
         dl_wzero     <= 1'b0;
         dl_waddr     <= '0;
         dl_raddr     <= '0;
         coef_addr    <= '0;
         mac_clr      <= 1'b0;
         mac_en       <= 1'b0;
         out_valid    <= 1'b0;
         busy         <= 1'b0;
         sample_count <= '0;
         out_count    <= '0;
      end else begin
         in_ready     <= 1'b0;
         dl_we        <= 1'b0;
         dl_wzero     <= 1'b0;
         dl_waddr     <= '0;
         dl_raddr     <= '0;
         coef_addr    <= '0;
         mac_clr      <= 1'b0;
         mac_en       <= 1'b0;
         out_valid    <= 1'b0;
         busy         <= 1'b1;
         r_flush_pend <= w_pend_nxt;
         case (r_state)
            S_CLEAR_INIT: begin
               r_state  <= S_CLEAR;
               r_cnt    <= '0;
               dl_we    <= 1'b1;
               dl_wzero <= 1'b1;
            end
            S_CLEAR: begin
               if (r_cnt == L_LAST) begin
                  r_state  <= S_IDLE;
                  r_wptr   <= '0;
                  busy     <= 1'b0;
                  in_ready <= ~w_pend_nxt;
               end else begin
                  r_cnt    <= r_cnt + 1'b1;
                  dl_we    <= 1'b1;
                  dl_wzero <= 1'b1;
                  dl_waddr <= r_cnt + 1'b1;
               end
            end
            S_IDLE: begin
               if (w_hs) begin
                  r_state      <= S_WRITE;
                  r_zero_pass  <= 1'b0;
                  sample_count <= sample_count + 1'b1;
                  dl_we        <= 1'b1;
                  dl_waddr     <= r_wptr;
                  mac_clr      <= 1'b1;
               end else if (r_flush_pend) begin
                  r_state      <= S_WRITE;
                  r_zero_pass  <= 1'b1;
                  r_flush_rem  <= L_LAST;
                  r_flush_pend <= 1'b0;
                  r_flush_act  <= 1'b1;
                  dl_we        <= 1'b1;
                  dl_wzero     <= 1'b1;
                  dl_waddr     <= r_wptr;
                  mac_clr      <= 1'b1;
               end else begin
                  busy     <= 1'b0;
                  in_ready <= ~w_pend_nxt;
               end
            end
            S_WRITE: begin
               r_state   <= S_MAC;
               r_cnt     <= '0;
               mac_en    <= 1'b1;
               dl_raddr  <= w_rd_nxt;
            end
            S_MAC: begin
               if (r_cnt == L_LAST) begin
                  r_state   <= S_DONE;
                  out_valid <= 1'b1;
                  out_count <= out_count + 1'b1;
               end else begin
                  r_cnt     <= w_t_nxt;
                  mac_en    <= 1'b1;
                  coef_addr <= w_t_nxt;
                  dl_raddr  <= w_rd_nxt;
               end
            end
            S_DONE: begin
               r_wptr <= w_wptr_nxt;
               if (r_zero_pass && r_flush_rem > AW'(1)) begin
                  r_state     <= S_WRITE;
                  r_flush_rem <= r_flush_rem - 1'b1;
                  dl_we       <= 1'b1;
                  dl_wzero    <= 1'b1;
                  dl_waddr    <= w_wptr_nxt;
                  mac_clr     <= 1'b1;
               end else begin
                  r_state     <= S_IDLE;
                  r_zero_pass <= 1'b0;
                  r_flush_act <= 1'b0;
                  busy        <= 1'b0;
                  in_ready    <= ~w_pend_nxt;
               end
            end
            default: r_state <= S_CLEAR_INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: scoreboard bench with a pass-level reference model of the FIR sequencer
module tb_fir_mac_sequencer;
   localparam int TAPS  = 9;
   localparam int AW    = 4;
   localparam int CNT_W = 16;

   typedef struct {
      bit          zero;
      int          waddr;
      logic [15:0] sc;
      int          hs;
   } rec_t;

   logic             clk = 1'b0;
   logic             reset, in_valid, flush;
   logic             in_ready, dl_we, dl_wzero, mac_clr, mac_en, out_valid, busy;
   logic [AW-1:0]    dl_waddr, dl_raddr, coef_addr;
   logic [CNT_W-1:0] sample_count, out_count;

   rec_t        q[$];
   int          n_vec = 0, n_err = 0, cyc = 0, mwptr = 0, zero_out = 0;
   logic [15:0] msc = '0, moc = '0;
   bit          mon_en = 1'b1;

   fir_mac_sequencer #(.TAPS(TAPS), .AW(AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .dl_we(dl_we), .dl_wzero(dl_wzero), .dl_waddr(dl_waddr), .dl_raddr(dl_raddr),
      .coef_addr(coef_addr), .mac_clr(mac_clr), .mac_en(mac_en), .out_valid(out_valid),
      .busy(busy), .sample_count(sample_count), .out_count(out_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void push_zero();
      for (int i = 0; i < TAPS - 1; i++) begin
         q.push_back('{1'b1, mwptr, msc, 0});
         mwptr = (mwptr + 1) % TAPS;
      end
      zero_out += TAPS - 1;
   endfunction

   // Reference monitor: each pass = write, TAPS products walking backwards through the ring, then a result strobe
   initial begin
      int   t;
      rec_t cur;
      t = -1;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            t = -1;
            continue;
         end
         if (zero_out > 0) chk("in_ready_during_flush", in_ready, 0);
         if (t < 0) begin
            if (mac_clr) begin
               chk("pass_queued", q.size() != 0, 1);
               if (q.size() != 0) begin
                  cur = q[0];
                  chk("write", {dl_we, dl_wzero, busy}, {1'b1, cur.zero, 1'b1});
                  chk("waddr", dl_waddr, cur.waddr);
                  if (!cur.zero) chk("write_latency", cyc, cur.hs);
                  t = 0;
               end
            end else chk("idle_quiet", {mac_en, out_valid}, 0);
         end else if (t < TAPS) begin
            chk("mac_en", {mac_en, mac_clr, dl_we, out_valid}, 4'b1000);
            chk("coef_addr", coef_addr, t);
            chk("raddr", dl_raddr, (cur.waddr + TAPS - t) % TAPS);
            t++;
         end else begin
            chk("out_valid", {out_valid, mac_en}, 2'b10);
            if (!cur.zero) chk("out_latency", cyc, cur.hs + TAPS + 1);
            moc = moc + 1'b1;
            chk("out_count", out_count, moc);
            chk("sample_count", sample_count, cur.sc);
            void'(q.pop_front());
            if (cur.zero) zero_out--;
            t = -1;
         end
      end
   end

   task automatic send(input bit hold, input bit with_flush, output int hs);
      int w;
      w = 0;
      in_valid = 1'b1;
      while (!in_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk("in_ready_wait", in_ready, 1);
      hs = cyc + 1;
      if (in_ready) begin
         msc = msc + 1'b1;
         q.push_back('{1'b0, mwptr, msc, hs});
         mwptr = (mwptr + 1) % TAPS;
         if (with_flush) begin
            flush = 1'b1;
            if (zero_out == 0) push_zero();
         end
         @(negedge clk);
      end
      flush = 1'b0;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      if (zero_out == 0) push_zero();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 3000 && !(q.size() == 0 && in_ready); i++) @(negedge clk);
      chk("drain", {q.size() == 0, in_ready}, 2'b11);
      chk("final_sample_count", sample_count, msc);
      chk("final_out_count", out_count, moc);
   endtask

   task automatic check_clear();
      for (int k = 0; k < TAPS; k++) begin
         @(negedge clk);
         chk("clear_ctrl", {dl_we, dl_wzero, busy, in_ready, mac_en, out_valid}, 6'b111000);
         chk("clear_waddr", dl_waddr, k);
      end
      @(negedge clk);
      chk("clear_done_ready", {in_ready, busy}, 2'b10);
   endtask

   function automatic logic [63:0] all_out();
      return {13'b0, in_ready, dl_we, dl_wzero, dl_waddr, dl_raddr, coef_addr, mac_clr, mac_en,
              out_valid, busy, sample_count, out_count};
   endfunction

   initial begin
      #600000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int hs, prev, r;
      reset = 1'b1;
      in_valid = 1'b0;
      flush = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", all_out(), 0);
      reset = 1'b0;
      check_clear();
      // single sample
      send(0, 0, hs);
      drain();
      // ten back-to-back samples with in_valid held
      prev = 0;
      for (int i = 0; i < 10; i++) begin
         send(1, 0, hs);
         if (i > 0) chk("hold_spacing", hs - prev, TAPS + 3);
         prev = hs;
      end
      in_valid = 1'b0;
      drain();
      // three samples then a flush during the third pass; a second flush mid-drain must be ignored
      for (int i = 0; i < 3; i++) send(0, 0, hs);
      repeat (3) @(negedge clk);
      pulse_flush();
      repeat (30) @(negedge clk);
      pulse_flush();
      drain();
      repeat (15) @(negedge clk);
      // sample and flush in the same accepted cycle
      send(0, 1, hs);
      drain();
      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6) send(0, 0, hs);
         else if (r == 6) send(0, 1, hs);
         else if (r == 7) send(1, 0, hs);
         else begin
            drain();
            pulse_flush();
         end
         if (r != 7) in_valid = 1'b0;
         repeat ($urandom_range(0, 15)) @(negedge clk);
      end
      in_valid = 1'b0;
      drain();
      // reset in the middle of a MAC sweep
      mon_en = 1'b0;
      send(0, 0, hs);
      for (int i = 0; i < 50 && !(mac_en && coef_addr == 4); i++) @(negedge clk);
      chk("reached_tap4", {mac_en, coef_addr}, {1'b1, 4'd4});
      reset = 1'b1;
      @(negedge clk);
      chk("midop_reset_outputs", all_out(), 0);
      reset = 1'b0;
      q.delete();
      mwptr = 0;
      msc = '0;
      moc = '0;
      zero_out = 0;
      check_clear();
      chk("post_reset_counts", {sample_count, out_count}, 0);
      mon_en = 1'b1;
      send(0, 0, hs);
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
